spi_reg_decoder: RTL
====================

SPI_REG_DECODER -- requirements
Module: spi_reg_decoder

Interface
REQ-001 The block SHALL have parameter NREG, default 4, giving the number of 8-bit registers (legal range 1..128).
REQ-002 The block SHALL have parameter RESET_VAL, default 8'h00, giving the reset value of every register.
REQ-003 Port: clk  input  1  system clock (XTALCLK domain); the only clock in the block.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: sclk  input  1  raw SPI clock from pin, asynchronous to clk.
REQ-006 Port: cs  input  1  raw SPI chip select from pin, active-low, asynchronous to clk.
REQ-007 Port: mosi  input  1  raw SPI data in from pin, asynchronous to clk.
REQ-008 Port: miso  output  1  SPI data out.
REQ-009 Port: reg_out  output  8*NREG  register contents; register k occupies bits 8k+7..8k.
REQ-010 Port: wr_strobe  output  NREG  one-clk pulse on bit k when register k is written.
REQ-011 Port: frame_err  output  1  one-clk pulse on a malformed frame.

Function
REQ-012 sclk, cs and mosi SHALL each pass through a 2-flop synchroniser, plus one further flop on sclk and cs for edge detection.
REQ-013 Correct operation SHALL be required only when clk is at least 4x the SCLK frequency and cs high time is at least 3 clk periods.
REQ-014 mosi SHALL be sampled on each detected sclk falling edge while synchronised cs is low.
REQ-015 Frame format SHALL be 16 bits, MSB first: bit 15 = W (1 = write, 0 = read), bits 14..8 = address, bits 7..0 = data.
REQ-016 The FSM SHALL have states IDLE, ADDR, DATA and WAIT_CS.
REQ-017 IDLE SHALL go to ADDR on a detected cs falling edge, with the bit counter cleared.
REQ-018 ADDR SHALL go to DATA after the 8th sampled bit, latching W and the address.
REQ-019 DATA SHALL go to WAIT_CS after the 16th sampled bit.
REQ-020 WAIT_CS SHALL ignore further sclk edges and go to IDLE on a detected cs rising edge.
REQ-021 On the 16th bit of a write frame with address < NREG, register[address] SHALL take the data byte, and wr_strobe[address] SHALL pulse, on the clk cycle after the edge detect.
REQ-022 A write frame with address >= NREG SHALL change no register, assert no wr_strobe bit, and pulse frame_err once.
REQ-023 A cs rising edge detected in ADDR or DATA SHALL pulse frame_err once, return the FSM to IDLE and write nothing.
REQ-024 A read frame SHALL never modify registers or assert wr_strobe.
REQ-025 A write and an incoming cs rising edge detected on the same clk cycle as the 16th bit SHALL complete the write without error and go directly to IDLE.
REQ-026 Back-to-back frames SHALL be accepted without lost bits, given the cs high time in REQ-013.

Reset
REQ-027 While rst is high, reg_out SHALL equal RESET_VAL in every register, and miso, wr_strobe and frame_err SHALL be 0.
REQ-028 While rst is high, the FSM SHALL be in IDLE, with the counter and shift register cleared and the synchroniser flops set to idle levels (cs = 1, sclk = 0).
REQ-029 If cs is low when rst deasserts, the block SHALL go to WAIT_CS and ignore that partial frame without asserting frame_err.

Configuration
REQ-030 With macro SPI_READBACK_EN defined, on a read frame with address < NREG the block SHALL drive register[address] bit 7 on miso within 2 clk cycles of the 8th bit.
REQ-031 With SPI_READBACK_EN defined, miso SHALL shift to the next lower bit on each detected sclk rising edge in DATA.
REQ-032 With SPI_READBACK_EN defined, miso SHALL be 0 in all other states and for read addresses >= NREG.
REQ-033 Without SPI_READBACK_EN, miso SHALL be constant 0 and read frames SHALL complete silently without frame_err.

Verification
REQ-034 Reset, then write frame 0x8155 -> reg_out register 1 = 0x55, wr_strobe = 4'b0010 for exactly 1 clk, frame_err = 0.
REQ-035 Write 0x80A5, then read frame 0x0000 with SPI_READBACK_EN defined -> miso bits during DATA = 1,0,1,0,0,1,0,1.
REQ-036 cs raised after 11 bits of 0x82FF -> frame_err pulses once; reg_out unchanged.
REQ-037 Write 0x9012 (address 16, NREG = 4) -> frame_err pulses once; no wr_strobe; registers unchanged.
REQ-038 20 sclk cycles in one cs window carrying 0x8377 plus 4 extra bits -> register 3 = 0x77; extra bits ignored; no error.
REQ-039 rst asserted at bit 10 of a write frame with cs held low -> all registers = RESET_VAL; no write or frame_err for that frame; the next full frame is accepted normally.

Source files
------------

// File: rtl/spi_reg_decoder.sv
// SPI slave register file: 16-bit frames (W, 7-bit address, 8-bit data), all
// logic in the clk domain with synchronised pin inputs.
// Optional feature: define SPI_READBACK_EN to return register contents on miso
// during read frames; without it miso is tied low.
module spi_reg_decoder #(
  parameter int unsigned NREG      = 4,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic [8*NREG-1:0] reg_out,
  output logic [NREG-1:0]   wr_strobe,
  output logic              frame_err
);

  localparam int unsigned AW = 7;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT_CS} state_t;

  state_t         state;
  logic           sclk_m, sclk_s, sclk_d;
  logic           cs_m, cs_s, cs_d;
  logic           mosi_m, mosi_s;
  logic [CW-1:0]  cnt;
  logic [6:0]     shift_q;
  logic           w_q;
  logic [AW-1:0]  addr_q;
  logic [1:0]     settle;
  logic [7:0]     regs [NREG];

  logic           sclk_fall_c, sclk_rise_c, cs_fall_c, cs_rise_c;
  logic [7:0]     bit_in_c;
  logic [AW-1:0]  addr_next_c;
  logic           addr_ok_c, addr_next_ok_c;

  // Two-flop synchronisers plus an edge-detect stage on sclk and cs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_m <= 1'b0; sclk_s <= 1'b0; sclk_d <= 1'b0;
      cs_m   <= 1'b1; cs_s   <= 1'b1; cs_d   <= 1'b1;
      mosi_m <= 1'b0; mosi_s <= 1'b0;
    end else begin
      sclk_m <= sclk;   sclk_s <= sclk_m; sclk_d <= sclk_s;
      cs_m   <= cs;     cs_s   <= cs_m;   cs_d   <= cs_s;
      mosi_m <= mosi;   mosi_s <= mosi_m;
    end
  end

  assign sclk_fall_c    = sclk_d & ~sclk_s;
  assign sclk_rise_c    = ~sclk_d & sclk_s;
  assign cs_fall_c      = cs_d & ~cs_s;
  assign cs_rise_c      = ~cs_d & cs_s;
  assign bit_in_c       = {shift_q, mosi_s};
  assign addr_next_c    = {shift_q[5:0], mosi_s};
  assign addr_ok_c      = 32'(addr_q) < NREG;
  assign addr_next_ok_c = 32'(addr_next_c) < NREG;

`ifdef SPI_READBACK_EN
  logic [7:0] tx;
  logic [7:0] rd_byte_c;

  // Register selected by the address being completed this cycle
  always_comb begin
    rd_byte_c = 8'h00;
    for (int k = 0; k < int'(NREG); k++) begin
      if (AW'(k) == addr_next_c) rd_byte_c = regs[k];
    end
  end
`endif

  // Frame FSM, register file and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_q   <= '0;
      w_q       <= 1'b0;
      addr_q    <= '0;
      settle    <= '0;
      miso      <= 1'b0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
`ifdef SPI_READBACK_EN
      tx        <= '0;
`endif
      for (int k = 0; k < int'(NREG); k++) regs[k] <= RESET_VAL;
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      if (settle != 2'd3) settle <= settle + 2'd1;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          // cs already low as reset lifted: skip that partial frame quietly
          if (settle != 2'd3 && !cs_s) begin
            state <= WAIT_CS;
          end else if (cs_fall_c) begin
            state   <= ADDR;
            cnt     <= '0;
            shift_q <= '0;
          end
        end
        ADDR: begin
          miso <= 1'b0;
          if (cs_rise_c) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (sclk_fall_c) begin
            shift_q <= bit_in_c[6:0];
            cnt     <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              w_q    <= shift_q[6];
              addr_q <= addr_next_c;
              state  <= DATA;
`ifdef SPI_READBACK_EN
              if (!shift_q[6] && addr_next_ok_c) begin
                tx   <= rd_byte_c;
                miso <= rd_byte_c[7];
              end else begin
                tx   <= '0;
              end
`endif
            end
          end
        end
        DATA: begin
          if (sclk_fall_c && cnt == 4'd15) begin
            // 16th bit wins over a coincident cs rise
            miso  <= 1'b0;
            state <= cs_rise_c ? IDLE : WAIT_CS;
            if (w_q) begin
              if (addr_ok_c) begin
                for (int k = 0; k < int'(NREG); k++) begin
                  if (AW'(k) == addr_q) begin
                    regs[k]      <= bit_in_c;
                    wr_strobe[k] <= 1'b1;
                  end
                end
              end else begin
                frame_err <= 1'b1;
              end
            end
          end else if (cs_rise_c) begin
            miso      <= 1'b0;
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (sclk_fall_c) begin
            shift_q <= bit_in_c[6:0];
            cnt     <= cnt + 4'd1;
          end else if (sclk_rise_c) begin
`ifdef SPI_READBACK_EN
            tx   <= {tx[6:0], 1'b0};
            miso <= tx[6];
`else
            miso <= 1'b0;
`endif
          end
        end
        WAIT_CS: begin
          miso <= 1'b0;
          if (cs_rise_c) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flatten register file onto reg_out
  for (genvar gi = 0; gi < int'(NREG); gi++) begin : g_out
    assign reg_out[8*gi +: 8] = regs[gi];
  end

endmodule
